// File: rtl/branch_rs.sv
// Reservation station for the branch unit: holds dispatched branches, snoops the
// ALU and LS result buses for missing operands, and issues one ready branch per cycle.
module branch_rs #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flushEn,
    input  logic              inEn,
    input  logic [OP_W-1:0]   inOpCode,
    input  logic [DATA_W-1:0] inOpO,
    input  logic [DATA_W-1:0] inOpT,
    input  logic              inRdyO,
    input  logic              inRdyT,
    input  logic [TAG_W-1:0]  inTagO,
    input  logic [TAG_W-1:0]  inTagT,
    input  logic [DATA_W-1:0] inImm,
    input  logic [ADDR_W-1:0] inPC,
    input  logic [1:0]        inBNum,
    input  logic              inPred,
    input  logic              aluCdbEn,
    input  logic [TAG_W-1:0]  aluCdbTag,
    input  logic [DATA_W-1:0] aluCdbData,
    input  logic              lsCdbEn,
    input  logic [TAG_W-1:0]  lsCdbTag,
    input  logic [DATA_W-1:0] lsCdbData,
    output logic              rsFull,
    output logic              BranchWorkEn,
    output logic [DATA_W-1:0] operandO,
    output logic [DATA_W-1:0] operandT,
    output logic [OP_W-1:0]   opCode,
    output logic [DATA_W-1:0] imm,
    output logic [ADDR_W-1:0] PC,
    output logic [1:0]        bNum,
    output logic              pred
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  rdy_o;
    logic [DEPTH-1:0]  rdy_t;
    logic [DEPTH-1:0]  e_pred;
    logic [OP_W-1:0]   e_op   [DEPTH];
    logic [TAG_W-1:0]  e_tag_o[DEPTH];
    logic [TAG_W-1:0]  e_tag_t[DEPTH];
    logic [DATA_W-1:0] e_val_o[DEPTH];
    logic [DATA_W-1:0] e_val_t[DEPTH];
    logic [DATA_W-1:0] e_imm  [DEPTH];
    logic [ADDR_W-1:0] e_pc   [DEPTH];
    logic [1:0]        e_bnum [DEPTH];

    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  free_idx;
    logic              alloc_en;
    logic              in_rdy_o;
    logic              in_rdy_t;
    logic [DATA_W-1:0] in_val_o;
    logic [DATA_W-1:0] in_val_t;

    assign rsFull   = &valid;
    assign alloc_en = inEn && !rsFull;

    // Lowest index wins for both issue select and free-slot search.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && rdy_o[i] && rdy_t[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Same-cycle bypass for a dispatching branch; ALU beats LS on a shared tag.
    always_comb begin
        in_rdy_o = inRdyO;
        in_val_o = inOpO;
        in_rdy_t = inRdyT;
        in_val_t = inOpT;
        if (!inRdyO) begin
            if (aluCdbEn && aluCdbTag == inTagO) begin
                in_rdy_o = 1'b1;
                in_val_o = aluCdbData;
            end else if (lsCdbEn && lsCdbTag == inTagO) begin
                in_rdy_o = 1'b1;
                in_val_o = lsCdbData;
            end
        end
        if (!inRdyT) begin
            if (aluCdbEn && aluCdbTag == inTagT) begin
                in_rdy_t = 1'b1;
                in_val_t = aluCdbData;
            end else if (lsCdbEn && lsCdbTag == inTagT) begin
                in_rdy_t = 1'b1;
                in_val_t = lsCdbData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid        <= '0;
            BranchWorkEn <= 1'b0;
            operandO     <= '0;
            operandT     <= '0;
            opCode       <= '0;
            imm          <= '0;
            PC           <= '0;
            bNum         <= '0;
            pred         <= 1'b0;
        end else if (flushEn) begin
            valid        <= '0;
            BranchWorkEn <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && !rdy_o[i]) begin
                    if (aluCdbEn && aluCdbTag == e_tag_o[i]) begin
                        rdy_o[i]   <= 1'b1;
                        e_val_o[i] <= aluCdbData;
                    end else if (lsCdbEn && lsCdbTag == e_tag_o[i]) begin
                        rdy_o[i]   <= 1'b1;
                        e_val_o[i] <= lsCdbData;
                    end
                end
                if (valid[i] && !rdy_t[i]) begin
                    if (aluCdbEn && aluCdbTag == e_tag_t[i]) begin
                        rdy_t[i]   <= 1'b1;
                        e_val_t[i] <= aluCdbData;
                    end else if (lsCdbEn && lsCdbTag == e_tag_t[i]) begin
                        rdy_t[i]   <= 1'b1;
                        e_val_t[i] <= lsCdbData;
                    end
                end
            end

            BranchWorkEn <= sel_found;
            if (sel_found) begin
                valid[sel_idx] <= 1'b0;
                operandO       <= e_val_o[sel_idx];
                operandT       <= e_val_t[sel_idx];
                opCode         <= e_op[sel_idx];
                imm            <= e_imm[sel_idx];
                PC             <= e_pc[sel_idx];
                bNum           <= e_bnum[sel_idx];
                pred           <= e_pred[sel_idx];
            end

            // The free slot was invalid before the edge, so it never collides with the issued one.
            if (alloc_en) begin
                valid[free_idx]   <= 1'b1;
                e_op[free_idx]    <= inOpCode;
                rdy_o[free_idx]   <= in_rdy_o;
                rdy_t[free_idx]   <= in_rdy_t;
                e_tag_o[free_idx] <= inTagO;
                e_tag_t[free_idx] <= inTagT;
                e_val_o[free_idx] <= in_val_o;
                e_val_t[free_idx] <= in_val_t;
                e_imm[free_idx]   <= inImm;
                e_pc[free_idx]    <= inPC;
                e_bnum[free_idx]  <= inBNum;
                e_pred[free_idx]  <= inPred;
            end
        end
    end

endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs: dispatch, bypass, wakeup, full, priority, flush, reset.
module tb_branch_rs;

    logic        clk = 1'b0;
    logic        rst, flushEn, inEn;
    logic [2:0]  inOpCode;
    logic [31:0] inOpO, inOpT, inImm, inPC;
    logic        inRdyO, inRdyT, inPred;
    logic [3:0]  inTagO, inTagT;
    logic [1:0]  inBNum;
    logic        aluCdbEn, lsCdbEn;
    logic [3:0]  aluCdbTag, lsCdbTag;
    logic [31:0] aluCdbData, lsCdbData;
    logic        rsFull, BranchWorkEn, pred;
    logic [31:0] operandO, operandT, imm, PC;
    logic [2:0]  opCode;
    logic [1:0]  bNum;

    int checks   = 0;
    int failures = 0;

    branch_rs dut (
        .clk(clk), .rst(rst), .flushEn(flushEn), .inEn(inEn), .inOpCode(inOpCode),
        .inOpO(inOpO), .inOpT(inOpT), .inRdyO(inRdyO), .inRdyT(inRdyT),
        .inTagO(inTagO), .inTagT(inTagT), .inImm(inImm), .inPC(inPC),
        .inBNum(inBNum), .inPred(inPred),
        .aluCdbEn(aluCdbEn), .aluCdbTag(aluCdbTag), .aluCdbData(aluCdbData),
        .lsCdbEn(lsCdbEn), .lsCdbTag(lsCdbTag), .lsCdbData(lsCdbData),
        .rsFull(rsFull), .BranchWorkEn(BranchWorkEn), .operandO(operandO),
        .operandT(operandT), .opCode(opCode), .imm(imm), .PC(PC), .bNum(bNum), .pred(pred)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inEn = 1'b0; flushEn = 1'b0; aluCdbEn = 1'b0; lsCdbEn = 1'b0;
    endtask

    task automatic dispatch(input logic [2:0] op, input logic [31:0] o, input logic [31:0] t,
                            input logic ro, input logic rt, input logic [3:0] tgo,
                            input logic [3:0] tgt, input logic [31:0] im, input logic [31:0] pc,
                            input logic [1:0] bn, input logic pr);
        inEn = 1'b1; inOpCode = op; inOpO = o; inOpT = t; inRdyO = ro; inRdyT = rt;
        inTagO = tgo; inTagT = tgt; inImm = im; inPC = pc; inBNum = bn; inPred = pr;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        dispatch(3'd0, 32'd0, 32'd0, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'd0, 2'd0, 1'b0);
        inEn = 1'b0;
        aluCdbTag = 4'd0; aluCdbData = 32'd0; lsCdbTag = 4'd0; lsCdbData = 32'd0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (rsFull !== 1'b0) begin failures++; $display("FAIL reset_rsfull got=%0h exp=0", rsFull); end
        checks++; if (BranchWorkEn !== 1'b0) begin failures++; $display("FAIL reset_en got=%0h exp=0", BranchWorkEn); end
        checks++; if (PC !== 32'd0 || operandO !== 32'd0) begin failures++; $display("FAIL reset_regs pc=%0h opO=%0h exp=0", PC, operandO); end

        dispatch(3'd0, 32'd5, 32'd5, 1'b1, 1'b1, 4'd0, 4'd0, 32'd8, 32'h100, 2'd2, 1'b1);
        tick(); idle();
        checks++; if (BranchWorkEn !== 1'b0) begin failures++; $display("FAIL first_latency got=%0h exp=0", BranchWorkEn); end
        tick();
        checks++; if (BranchWorkEn !== 1'b1) begin failures++; $display("FAIL first_issue_en got=%0h exp=1", BranchWorkEn); end
        checks++; if (operandO !== 32'd5 || operandT !== 32'd5) begin failures++; $display("FAIL first_ops got=%0h/%0h exp=5/5", operandO, operandT); end
        checks++; if (PC !== 32'h100 || imm !== 32'd8 || bNum !== 2'd2 || pred !== 1'b1 || opCode !== 3'd0)
            begin failures++; $display("FAIL first_fields pc=%0h imm=%0h bnum=%0h pred=%0h op=%0h exp=100/8/2/1/0", PC, imm, bNum, pred, opCode); end
        tick();
        checks++; if (BranchWorkEn !== 1'b0) begin failures++; $display("FAIL first_single got=%0h exp=0", BranchWorkEn); end
    endtask

    task automatic test_wakeup_bypass();
        dispatch(3'd1, 32'd0, 32'h20, 1'b0, 1'b1, 4'd3, 4'd0, 32'd4, 32'h140, 2'd1, 1'b0);
        aluCdbEn = 1'b1; aluCdbTag = 4'd3; aluCdbData = 32'h7;
        tick(); idle();
        tick();
        checks++; if (BranchWorkEn !== 1'b1 || operandO !== 32'h7 || operandT !== 32'h20 || opCode !== 3'd1)
            begin failures++; $display("FAIL bypass_issue en=%0h opO=%0h opT=%0h op=%0h exp=1/7/20/1", BranchWorkEn, operandO, operandT, opCode); end

        dispatch(3'd1, 32'd0, 32'h21, 1'b0, 1'b1, 4'd3, 4'd0, 32'd4, 32'h180, 2'd1, 1'b0);
        tick(); idle();
        tick();
        checks++; if (BranchWorkEn !== 1'b0) begin failures++; $display("FAIL wait_no_issue got=%0h exp=0", BranchWorkEn); end
        aluCdbEn = 1'b1; aluCdbTag = 4'd3; aluCdbData = 32'h9;
        tick(); idle();
        checks++; if (BranchWorkEn !== 1'b0) begin failures++; $display("FAIL wake_latency got=%0h exp=0", BranchWorkEn); end
        tick();
        checks++; if (BranchWorkEn !== 1'b1 || operandO !== 32'h9 || PC !== 32'h180)
            begin failures++; $display("FAIL wake_issue en=%0h opO=%0h pc=%0h exp=1/9/180", BranchWorkEn, operandO, PC); end

        // Second operand woken by LS alone.
        dispatch(3'd2, 32'h1, 32'd0, 1'b1, 1'b0, 4'd0, 4'd10, 32'd0, 32'h1c0, 2'd0, 1'b1);
        tick(); idle();
        lsCdbEn = 1'b1; lsCdbTag = 4'd10; lsCdbData = 32'h44;
        tick(); idle();
        tick();
        checks++; if (BranchWorkEn !== 1'b1 || operandT !== 32'h44 || PC !== 32'h1c0)
            begin failures++; $display("FAIL ls_wake en=%0h opT=%0h pc=%0h exp=1/44/1c0", BranchWorkEn, operandT, PC); end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            dispatch(3'd4, 32'd0, 32'(i), 1'b0, 1'b1, 4'd9, 4'd0, 32'd0, 32'h200 + 32'(4 * i), 2'd0, 1'b0);
            tick();
        end
        idle();
        checks++; if (rsFull !== 1'b1) begin failures++; $display("FAIL full_set got=%0h exp=1", rsFull); end
        dispatch(3'd4, 32'd0, 32'd0, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'h300, 2'd0, 1'b0);
        tick(); idle();
        checks++; if (rsFull !== 1'b1 || BranchWorkEn !== 1'b0) begin failures++; $display("FAIL full_drop full=%0h en=%0h exp=1/0", rsFull, BranchWorkEn); end
        lsCdbEn = 1'b1; lsCdbTag = 4'd9; lsCdbData = 32'h55;
        tick(); idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (BranchWorkEn !== 1'b1 || PC !== 32'h200 + 32'(4 * i) || operandO !== 32'h55 || operandT !== 32'(i))
                begin failures++; $display("FAIL full_drain%0d en=%0h pc=%0h opO=%0h opT=%0h exp=1/%0h/55/%0h", i, BranchWorkEn, PC, operandO, operandT, 32'h200 + 32'(4 * i), i); end
            checks++; if (rsFull !== 1'b0) begin failures++; $display("FAIL full_clear%0d got=%0h exp=0", i, rsFull); end
        end
        tick();
        checks++; if (BranchWorkEn !== 1'b0) begin failures++; $display("FAIL full_dropped_issued got=%0h exp=0", BranchWorkEn); end
    endtask

    task automatic test_priority();
        dispatch(3'd5, 32'd0, 32'd0, 1'b0, 1'b1, 4'd5, 4'd0, 32'd0, 32'h400, 2'd0, 1'b0); tick();
        dispatch(3'd5, 32'd0, 32'd0, 1'b0, 1'b1, 4'd6, 4'd0, 32'd0, 32'h404, 2'd1, 1'b0); tick();
        dispatch(3'd5, 32'd0, 32'd0, 1'b0, 1'b1, 4'd5, 4'd0, 32'd0, 32'h408, 2'd2, 1'b0); tick();
        idle();
        aluCdbEn = 1'b1; aluCdbTag = 4'd5; aluCdbData = 32'h11;
        tick(); idle();
        tick();
        checks++; if (BranchWorkEn !== 1'b1 || PC !== 32'h400) begin failures++; $display("FAIL prio_first en=%0h pc=%0h exp=1/400", BranchWorkEn, PC); end
        tick();
        checks++; if (BranchWorkEn !== 1'b1 || PC !== 32'h408 || bNum !== 2'd2) begin failures++; $display("FAIL prio_second en=%0h pc=%0h bnum=%0h exp=1/408/2", BranchWorkEn, PC, bNum); end
        tick();
        checks++; if (BranchWorkEn !== 1'b0) begin failures++; $display("FAIL prio_idle got=%0h exp=0", BranchWorkEn); end
        aluCdbEn = 1'b1; aluCdbTag = 4'd6; aluCdbData = 32'h1;
        lsCdbEn  = 1'b1; lsCdbTag  = 4'd6; lsCdbData  = 32'h2;
        tick(); idle();
        tick();
        checks++; if (BranchWorkEn !== 1'b1 || PC !== 32'h404 || operandO !== 32'h1)
            begin failures++; $display("FAIL cdb_prio_wake en=%0h pc=%0h opO=%0h exp=1/404/1", BranchWorkEn, PC, operandO); end
        dispatch(3'd6, 32'd0, 32'h3c, 1'b0, 1'b1, 4'd7, 4'd0, 32'd0, 32'h440, 2'd3, 1'b0);
        aluCdbEn = 1'b1; aluCdbTag = 4'd7; aluCdbData = 32'h3;
        lsCdbEn  = 1'b1; lsCdbTag  = 4'd7; lsCdbData  = 32'h4;
        tick(); idle();
        tick();
        checks++; if (BranchWorkEn !== 1'b1 || PC !== 32'h440 || operandO !== 32'h3)
            begin failures++; $display("FAIL cdb_prio_bypass en=%0h pc=%0h opO=%0h exp=1/440/3", BranchWorkEn, PC, operandO); end
        tick();
    endtask

    task automatic test_back_to_back();
        dispatch(3'd2, 32'hA, 32'hB, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'h500, 2'd0, 1'b0); tick();
        dispatch(3'd3, 32'hC, 32'hD, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'h504, 2'd1, 1'b1); tick();
        idle();
        checks++; if (BranchWorkEn !== 1'b1 || PC !== 32'h500 || operandO !== 32'hA) begin failures++; $display("FAIL b2b_first en=%0h pc=%0h opO=%0h exp=1/500/a", BranchWorkEn, PC, operandO); end
        tick();
        checks++; if (BranchWorkEn !== 1'b1 || PC !== 32'h504 || operandT !== 32'hD || opCode !== 3'd3)
            begin failures++; $display("FAIL b2b_second en=%0h pc=%0h opT=%0h op=%0h exp=1/504/d/3", BranchWorkEn, PC, operandT, opCode); end
        tick();
        checks++; if (BranchWorkEn !== 1'b0 || PC !== 32'h504) begin failures++; $display("FAIL b2b_hold en=%0h pc=%0h exp=0/504", BranchWorkEn, PC); end
    endtask

    task automatic test_flush();
        dispatch(3'd0, 32'd0, 32'd1, 1'b0, 1'b1, 4'd11, 4'd0, 32'd0, 32'h600, 2'd0, 1'b0); tick();
        dispatch(3'd0, 32'd0, 32'd1, 1'b0, 1'b1, 4'd12, 4'd0, 32'd0, 32'h604, 2'd0, 1'b0); tick();
        dispatch(3'd0, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'h608, 2'd0, 1'b0); tick();
        idle();
        flushEn = 1'b1;
        tick(); idle();
        checks++; if (BranchWorkEn !== 1'b0 || rsFull !== 1'b0) begin failures++; $display("FAIL flush_clear en=%0h full=%0h exp=0/0", BranchWorkEn, rsFull); end
        aluCdbEn = 1'b1; aluCdbTag = 4'd11; aluCdbData = 32'h1;
        lsCdbEn  = 1'b1; lsCdbTag  = 4'd12; lsCdbData  = 32'h2;
        tick(); idle();
        tick();
        checks++; if (BranchWorkEn !== 1'b0) begin failures++; $display("FAIL flush_stale1 got=%0h exp=0", BranchWorkEn); end
        tick();
        checks++; if (BranchWorkEn !== 1'b0) begin failures++; $display("FAIL flush_stale2 got=%0h exp=0", BranchWorkEn); end
        // Flush arriving on the same edge an issue would happen.
        dispatch(3'd0, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'h60c, 2'd0, 1'b0); tick();
        idle(); flushEn = 1'b1;
        tick(); idle();
        checks++; if (BranchWorkEn !== 1'b0 || PC === 32'h60c) begin failures++; $display("FAIL flush_vs_issue en=%0h pc=%0h exp=0/not60c", BranchWorkEn, PC); end
    endtask

    task automatic test_mid_reset();
        dispatch(3'd7, 32'h3, 32'h4, 1'b1, 1'b1, 4'd0, 4'd0, 32'h10, 32'h700, 2'd3, 1'b1); tick();
        dispatch(3'd7, 32'd0, 32'h4, 1'b0, 1'b1, 4'd13, 4'd0, 32'h10, 32'h704, 2'd1, 1'b1); tick();
        idle();
        checks++; if (BranchWorkEn !== 1'b1 || PC !== 32'h700) begin failures++; $display("FAIL mid_pre en=%0h pc=%0h exp=1/700", BranchWorkEn, PC); end
        rst = 1'b1;
        tick(); rst = 1'b0;
        checks++; if (BranchWorkEn !== 1'b0 || rsFull !== 1'b0 || PC !== 32'd0 || operandO !== 32'd0 || operandT !== 32'd0 ||
                      imm !== 32'd0 || opCode !== 3'd0 || bNum !== 2'd0 || pred !== 1'b0)
            begin failures++; $display("FAIL mid_reset en=%0h full=%0h pc=%0h opO=%0h opT=%0h imm=%0h op=%0h bnum=%0h pred=%0h exp=all0",
                                       BranchWorkEn, rsFull, PC, operandO, operandT, imm, opCode, bNum, pred); end
        aluCdbEn = 1'b1; aluCdbTag = 4'd13; aluCdbData = 32'h5;
        tick(); idle();
        tick();
        checks++; if (BranchWorkEn !== 1'b0) begin failures++; $display("FAIL mid_stale got=%0h exp=0", BranchWorkEn); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_wakeup_bypass();
        test_full();
        test_priority();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
